// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader: splits a beat-count read request into Avalon-MM
// sub-bursts of at most MAX_BURST beats, one outstanding at a time.
// Returned beats are tagged with a running index across the whole request.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   read_addr/read_cnt   byte base address and beat count of a request
//   read_start           single-cycle request strobe (ignored while busy)
//   out_valid/idx/data   captured beat, one cycle after readdatavalid
//   busy                 accepted request in progress (through done cycle)
//   done                 pulse with the last out_valid (or after a 0-beat start)
//   read/address/burstcount/waitrequest/readdata/readdatavalid
//                        Avalon-MM read master
module sdram_burst_reader #(
    parameter int SDRAM_W   = 128,
    parameter int MAX_BURST = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        read_addr,
    input  logic [10:0]        read_cnt,
    input  logic               read_start,
    output logic               out_valid,
    output logic [10:0]        out_idx,
    output logic [SDRAM_W-1:0] out_data,
    output logic               busy,
    output logic               done,
    output logic               read,
    output logic [31:0]        address,
    output logic [10:0]        burstcount,
    input  logic               waitrequest,
    input  logic [SDRAM_W-1:0] readdata,
    input  logic               readdatavalid
);

    localparam logic [10:0] MAXB       = 11'(MAX_BURST);
    localparam logic [31:0] BEAT_BYTES = 32'(SDRAM_W / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          cur_addr_q, cur_addr_d;
    logic [10:0]          remaining_q, remaining_d;
    logic [10:0]          beat_idx_q, beat_idx_d;
    logic [10:0]          sub_q, sub_d;
    logic [10:0]          sub_left_q, sub_left_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 out_valid_q, out_valid_d;
    logic [10:0]          out_idx_q, out_idx_d;
    logic [SDRAM_W-1:0]   out_data_q, out_data_d;

    logic accept;
    logic start_go;
    logic start_zero;
    logic req_ack;
    logic beat;
    logic sub_end;
    logic last_beat;
    logic next_burst;

    function automatic logic [10:0] clip(input logic [10:0] n);
        return (n > MAXB) ? MAXB : n;
    endfunction

    // busy_q is still high in the done cycle, so a start there is dropped
    assign accept     = (state_q == S_IDLE) && !busy_q && read_start;
    assign start_go   = accept && (read_cnt != 11'd0);
    assign start_zero = accept && (read_cnt == 11'd0);
    assign req_ack    = (state_q == S_REQ) && !waitrequest;
    assign beat       = (state_q == S_DATA) && readdatavalid;
    assign sub_end    = beat && (sub_left_q == 11'd1);
    assign last_beat  = sub_end && (remaining_q == 11'd1);
    assign next_burst = sub_end && (remaining_q != 11'd1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_go) state_d = S_REQ;
            S_REQ:  if (req_ack) state_d = S_DATA;
            S_DATA: begin
                if (last_beat) begin
                    state_d = S_IDLE;
                end else if (next_burst) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Avalon request outputs; registered values stay put while stalled
    always_comb begin
        read       = (state_q == S_REQ);
        address    = read ? cur_addr_q : 32'd0;
        burstcount = read ? sub_q : 11'd0;
    end

    always_comb begin
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beat_idx_d  = beat_idx_q;
        sub_d       = sub_q;
        sub_left_d  = sub_left_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;

        if (start_go) begin
            cur_addr_d  = read_addr;
            remaining_d = read_cnt;
            beat_idx_d  = 11'd0;
            sub_d       = clip(read_cnt);
        end

        if (req_ack) begin
            sub_left_d = sub_q;
        end

        if (beat) begin
            out_valid_d = 1'b1;
            out_data_d  = readdata;
            out_idx_d   = beat_idx_q;
            beat_idx_d  = beat_idx_q + 11'd1;
            sub_left_d  = sub_left_q - 11'd1;
            remaining_d = remaining_q - 11'd1;
        end

        // advance past the finished sub-burst; address wraps at 2^32
        if (next_burst) begin
            cur_addr_d = cur_addr_q + 32'(sub_q) * BEAT_BYTES;
            sub_d      = clip(remaining_q - 11'd1);
        end

        busy_d = (state_d != S_IDLE) || last_beat;
        done_d = last_beat || start_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q  <= 32'd0;
            remaining_q <= 11'd0;
            beat_idx_q  <= 11'd0;
            sub_q       <= 11'd0;
            sub_left_q  <= 11'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 11'd0;
            out_data_q  <= '0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beat_idx_q  <= beat_idx_d;
            sub_q       <= sub_d;
            sub_left_q  <= sub_left_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_sdram_burst_reader.sv
// tb_sdram_burst_reader: table-driven requests against an Avalon slave
// model, with beat and request scoreboards plus corner-case sequences.
module tb_sdram_burst_reader;

    typedef struct {
        logic [31:0] addr;
        logic [10:0] cnt;
        int          stall;
        int          nreq;
    } vec_t;

    typedef struct {
        logic [10:0]  idx;
        logic [127:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [10:0] len;
    } req_t;

    logic         clk;
    logic         rst_n;
    logic [31:0]  read_addr;
    logic [10:0]  read_cnt;
    logic         read_start;
    logic         out_valid;
    logic [10:0]  out_idx;
    logic [127:0] out_data;
    logic         busy;
    logic         done;
    logic         read;
    logic [31:0]  address;
    logic [10:0]  burstcount;
    logic         waitrequest;
    logic [127:0] readdata;
    logic         readdatavalid;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int rd_cycles = 0;
    int n_acc = 0;
    int stall_left = 0;
    int stray_req = 0;
    int stray_done = 0;
    int pend_left = 0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] hold_addr = 32'd0;
    logic [10:0] hold_bc = 11'd0;
    logic prev_real = 1'b0;

    beat_t exp_q[$];
    req_t  req_q[$];
    vec_t  vecs[7];

    sdram_burst_reader #(
        .SDRAM_W  (128),
        .MAX_BURST(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_addr    (read_addr),
        .read_cnt     (read_cnt),
        .read_start   (read_start),
        .out_valid    (out_valid),
        .out_idx      (out_idx),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done),
        .read         (read),
        .address      (address),
        .burstcount   (burstcount),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] fdata(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // one cycle: sample DUT at negedge, then play the Avalon slave
    task automatic tick();
        beat_t e;
        req_t  r;
        @(negedge clk);
        chk("out_valid_lat", 128'(out_valid), 128'(prev_real));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexp_beat", 128'(out_valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_idx", 128'(out_idx), 128'(e.idx));
                chk("out_data", out_data, e.data);
                chk("done_w_beat", 128'(done), 128'(e.last));
                chk("busy_w_beat", 128'(busy), 128'(1));
            end
        end
        if (done) done_seen++;
        if (read) rd_cycles++;
        prev_real = 1'b0;
        if (!rst_n) begin
            pend_left     = 0;
            readdatavalid = 1'b0;
            waitrequest   = 1'b0;
        end else begin
            readdatavalid = 1'b0;
            if (pend_left > 0) begin
                readdatavalid = 1'b1;
                readdata      = fdata(pend_addr);
                pend_addr     = pend_addr + 32'd16;
                pend_left--;
                prev_real = 1'b1;
            end else if (stray_done < stray_req) begin
                readdatavalid = 1'b1;
                readdata      = {4{32'hBAD0_BAD0}};
                stray_done++;
            end
            if (read) begin
                if (waitrequest) begin
                    chk("hold_addr", 128'(address), 128'(hold_addr));
                    chk("hold_bc", 128'(burstcount), 128'(hold_bc));
                end
                hold_addr = address;
                hold_bc   = burstcount;
                if (stall_left > 0) begin
                    waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    waitrequest = 1'b0;
                    n_acc++;
                    if (req_q.size() == 0) begin
                        chk("unexp_req", 128'(read), 128'(0));
                    end else begin
                        r = req_q.pop_front();
                        chk("req_addr", 128'(address), 128'(r.addr));
                        chk("req_bc", 128'(burstcount), 128'(r.len));
                    end
                    pend_addr = address;
                    pend_left = int'(burstcount);
                end
            end else begin
                waitrequest = 1'b0;
            end
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [10:0] c);
        int rem;
        int l;
        int bi;
        logic [31:0] ca;
        beat_t b;
        req_t  r;
        rem = int'(c);
        ca  = a;
        bi  = 0;
        while (rem > 0) begin
            l = (rem > 8) ? 8 : rem;
            r.addr = ca;
            r.len  = 11'(l);
            req_q.push_back(r);
            for (int k = 0; k < l; k++) begin
                b.idx  = 11'(bi);
                b.data = fdata(ca + 32'(k * 16));
                b.last = (bi == int'(c) - 1);
                exp_q.push_back(b);
                bi++;
            end
            ca  = ca + 32'(l * 16);
            rem = rem - l;
        end
    endtask

    task automatic run_req(input logic [31:0] a, input logic [10:0] c,
                           input int stall, input int nreq, input int inj_at);
        int cyc;
        int a0;
        int d0;
        int r0;
        logic injected;
        push_exp(a, c);
        a0 = n_acc;
        d0 = done_seen;
        r0 = rd_cycles;
        stall_left = stall;
        read_addr  = a;
        read_cnt   = c;
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
        cyc = 0;
        injected = 1'b0;
        while (done_seen == d0 && cyc < 400) begin
            if (inj_at >= 0 && !injected &&
                int'(c) - exp_q.size() >= inj_at) begin
                read_addr  = 32'h9000;
                read_cnt   = 11'd3;
                read_start = 1'b1;
                injected   = 1'b1;
            end
            tick();
            read_start = 1'b0;
            cyc++;
        end
        chk("busy_at_done", 128'(busy), 128'(1));
        chk("done_cnt", 128'(done_seen - d0), 128'(1));
        chk("exp_left", 128'(exp_q.size()), 128'(0));
        chk("req_left", 128'(req_q.size()), 128'(0));
        chk("n_req", 128'(n_acc - a0), 128'(nreq));
        chk("read_cycles", 128'(rd_cycles - r0), 128'(nreq + stall));
        tick();
        chk("busy_after", 128'(busy), 128'(0));
        chk("done_after", 128'(done), 128'(0));
    endtask

    initial begin
        int r0;
        int cyc;
        vecs[0] = '{32'h0000_1000, 11'd4,  0, 1};
        vecs[1] = '{32'h0000_2000, 11'd20, 0, 3};
        vecs[2] = '{32'h0000_3000, 11'd5,  3, 1};
        vecs[3] = '{32'h0000_4000, 11'd8,  0, 1};
        vecs[4] = '{32'h0000_5000, 11'd9,  0, 2};
        vecs[5] = '{32'hFFFF_FFC0, 11'd12, 0, 2};
        vecs[6] = '{32'h0000_0010, 11'd1,  2, 1};

        rst_n         = 1'b0;
        read_addr     = 32'd0;
        read_cnt      = 11'd0;
        read_start    = 1'b0;
        waitrequest   = 1'b0;
        readdata      = '0;
        readdatavalid = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_idx", 128'(out_idx), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_read", 128'(read), 128'(0));
        chk("rst_address", 128'(address), 128'(0));
        chk("rst_burstcount", 128'(burstcount), 128'(0));
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_req(vecs[i].addr, vecs[i].cnt, vecs[i].stall,
                    vecs[i].nreq, -1);
        end

        // zero-beat request
        r0 = rd_cycles;
        read_addr  = 32'h7000;
        read_cnt   = 11'd0;
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
        chk("zero_done", 128'(done), 128'(1));
        chk("zero_busy", 128'(busy), 128'(0));
        tick();
        chk("zero_done_clr", 128'(done), 128'(0));
        chk("zero_busy2", 128'(busy), 128'(0));
        chk("zero_no_read", 128'(rd_cycles - r0), 128'(0));

        // start during DATA is ignored
        run_req(32'h0000_8000, 11'd8, 0, 1, 2);

        // reset in the middle of a burst, then stray readdatavalid
        push_exp(32'h0000_6000, 11'd4);
        read_addr  = 32'h0000_6000;
        read_cnt   = 11'd4;
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
        cyc = 0;
        while (exp_q.size() > 2 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("pre_rst_beats", 128'(exp_q.size()), 128'(2));
        rst_n     = 1'b0;
        prev_real = 1'b0;
        tick();
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_idx", 128'(out_idx), 128'(0));
        chk("mid_rst_out_data", out_data, 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_done", 128'(done), 128'(0));
        chk("mid_rst_read", 128'(read), 128'(0));
        chk("mid_rst_address", 128'(address), 128'(0));
        chk("mid_rst_bc", 128'(burstcount), 128'(0));
        rst_n = 1'b1;
        exp_q.delete();
        req_q.delete();
        stray_req = stray_req + 2;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stray_busy", 128'(busy), 128'(0));
            chk("stray_read", 128'(read), 128'(0));
        end
        run_req(32'h0000_6000, 11'd4, 0, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
